// File: rtl/charge_timer.sv
// Single-shot charging-duration timer: start launches a TIME_S second interval
// counted with an internal 1 s prescaler; HOLD blocks auto-restart while start stays high.
module charge_timer #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TIME_S      = 10,
    parameter int SEC_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             timing,
    output logic             done,
    output logic [SEC_W-1:0] remain_sec,
    output logic [1:0]       dbg_state
);

    localparam int PRE_W = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_FREQ_HZ - 1);
    localparam logic [SEC_W-1:0] SEC_LOAD = SEC_W'(TIME_S);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t             state_q;
    logic [PRE_W-1:0]   pre_q;
    logic [SEC_W-1:0]   remain_q;
    logic               timing_q;
    logic               done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            remain_q <= '0;
            timing_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= RUN;
                        pre_q    <= '0;
                        remain_q <= SEC_LOAD;
                        timing_q <= 1'b1;
                    end
                end
                RUN: begin
                    // start is deliberately not looked at here: no retrigger, no extension
                    if (pre_q == PRE_MAX) begin
                        pre_q    <= '0;
                        remain_q <= remain_q - SEC_W'(1);
                        if (remain_q == SEC_W'(1)) begin
                            timing_q <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= HOLD;
                        end
                    end else begin
                        pre_q <= pre_q + PRE_W'(1);
                    end
                end
                HOLD: begin
                    timing_q <= 1'b0;
                    remain_q <= '0;
                    if (!start) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q  <= IDLE;
                    timing_q <= 1'b0;
                    remain_q <= '0;
                end
            endcase
        end
    end

    assign timing     = timing_q;
    assign done       = done_q;
    assign remain_sec = remain_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_charge_timer.sv
// Directed bench for charge_timer: expected interval lengths are queued when a start
// is driven and compared against the measured timing pulse when the interval ends.
module tb_charge_timer;

    localparam int CLK  = 10;
    localparam int TS   = 3;
    localparam int SW   = 8;
    localparam int LEN  = TS * CLK;
    localparam logic [31:0] ST_IDLE = 32'd0;
    localparam logic [31:0] ST_HOLD = 32'd2;

    logic          clk;
    logic          reset;
    logic          start;
    logic          timing;
    logic          done;
    logic [SW-1:0] remain_sec;
    logic [1:0]    dbg_state;

    int n_assert;
    int n_fail;
    logic [15:0] exp_q[$];

    charge_timer #(
        .CLK_FREQ_HZ(CLK),
        .TIME_S     (TS),
        .SEC_W      (SW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .timing    (timing),
        .done      (done),
        .remain_sec(remain_sec),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_timing"}, 32'(timing), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_remain"}, 32'(remain_sec), 32'd0);
    endtask

    // Entered one cycle after start was sampled; follows the interval to its end.
    task automatic measure(input bit toggle);
        int k;
        logic [15:0] exp_len;
        chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        exp_len = (exp_q.size() != 0) ? exp_q.pop_front() : 16'd0;
        k = 0;
        while (timing === 1'b1 && k < 1000) begin
            chk("run_remain", 32'(remain_sec), 32'(TS - k / CLK));
            chk("run_done_low", 32'(done), 32'd0);
            if (toggle) start = 1'($urandom_range(0, 1));
            tick();
            k++;
        end
        chk("interval_len", 32'(k), 32'(exp_len));
        chk("done_pulse", 32'(done), 32'd1);
        chk("end_remain", 32'(remain_sec), 32'd0);
        chk("end_state_hold", 32'(dbg_state), ST_HOLD);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        reset    = 1'b0;
        start    = 1'b1;

        // 1. reset held with start high, then released with start low
        repeat (5) begin
            tick();
            chk_quiet("in_reset");
        end
        reset = 1'b1;
        start = 1'b0;
        repeat (3) begin
            tick();
            chk_quiet("post_reset");
            chk("post_reset_idle", 32'(dbg_state), ST_IDLE);
        end

        // 2. basic run with start kept high
        start = 1'b1;
        exp_q.push_back(16'(LEN));
        tick();
        chk("basic_rise", 32'(timing), 32'd1);
        measure(1'b0);
        tick();
        chk("basic_done_once", 32'(done), 32'd0);

        // 3. start held: stay in HOLD, then a low/high cycle restarts
        repeat (50) begin
            tick();
            chk_quiet("held");
            chk("held_state", 32'(dbg_state), ST_HOLD);
        end
        start = 1'b0;
        tick();
        chk("held_release_idle", 32'(dbg_state), ST_IDLE);
        chk("held_release_timing", 32'(timing), 32'd0);
        start = 1'b1;
        exp_q.push_back(16'(LEN));
        tick();
        chk("restart_rise", 32'(timing), 32'd1);
        measure(1'b0);
        start = 1'b0;
        tick();
        chk("restart_idle", 32'(dbg_state), ST_IDLE);

        // 4. start toggled throughout the interval
        start = 1'b1;
        exp_q.push_back(16'(LEN));
        tick();
        chk("toggle_rise", 32'(timing), 32'd1);
        measure(1'b1);
        start = 1'b0;
        tick();
        chk("toggle_idle", 32'(dbg_state), ST_IDLE);
        chk("toggle_done_once", 32'(done), 32'd0);

        // 5. reset asserted mid-interval, between clock edges
        start = 1'b1;
        tick();
        chk("abort_rise", 32'(timing), 32'd1);
        start = 1'b0;
        repeat (14) tick();
        chk("abort_pre_timing", 32'(timing), 32'd1);
        chk("abort_pre_remain", 32'(remain_sec), 32'd2);
        reset = 1'b0;
        #1;
        chk_quiet("abort_async");
        repeat (3) begin
            tick();
            chk_quiet("abort_hold");
        end
        reset = 1'b1;
        tick();
        chk_quiet("abort_release");
        chk("abort_idle", 32'(dbg_state), ST_IDLE);

        // 6. single-cycle start pulse
        start = 1'b1;
        exp_q.push_back(16'(LEN));
        tick();
        start = 1'b0;
        chk("pulse_rise", 32'(timing), 32'd1);
        measure(1'b0);
        tick();
        chk("pulse_back_idle", 32'(dbg_state), ST_IDLE);
        chk_quiet("pulse_after");

        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/charge_timer.md
Name: charge_timer

Overview:
- Single-shot charging-duration timer for the coin-operated phone charger.
- A start request from the coin/control FSM launches a fixed-length interval. `timing` stays high for exactly that interval; the charger relay follows it.
- A built-in prescaler turns the system clock into 1 s ticks. A seconds down-counter tracks the time remaining, for the display.

Parameters:
- CLK_FREQ_HZ, 50_000_000, clock frequency; ticks per second of the prescaler.
- TIME_S, 10, charging interval length in seconds (must be ≥1).
- SEC_W, 8, width of the remaining-seconds output (must hold TIME_S).

Ports:
- clk, input, 1, system clock; all logic on its rising edge.
- reset, input, 1, asynchronous, active-low reset (0 = reset asserted).
- start, input, 1, request to begin a timing interval; level-sampled.
- timing, output, 1, high while the interval is running.
- done, output, 1, one-cycle pulse when an interval expires.
- remain_sec, output, SEC_W, seconds remaining (display value).

Behaviour:
- Reset (reset=0, asynchronous, independent of clk):
  - state=IDLE, prescaler=0, remain_sec=0, timing=0, done=0.
  - Deassertion takes effect at the next clk edge.
- All outputs are registered; no combinational path from input to output.
- States: IDLE, RUN, HOLD.
- IDLE:
  - If start=1 at a clk edge: go to RUN, remain_sec←TIME_S, prescaler←0, timing←1.
  - timing is therefore high on the first edge after start is sampled (1-cycle latency).
- RUN:
  - Prescaler counts 0..CLK_FREQ_HZ-1 and wraps to 0.
  - A tick is the cycle in which prescaler = CLK_FREQ_HZ-1. Each tick decrements remain_sec.
  - On the tick where remain_sec=1 (so it reaches 0): timing←0, done←1 for one cycle, go to HOLD.
  - timing is high for exactly TIME_S*CLK_FREQ_HZ clock cycles.
  - start is ignored in RUN; no retrigger and no extension.
- HOLD:
  - timing=0, remain_sec=0.
  - Stay until start=0 is sampled, then return to IDLE.
  - This prevents auto-restart while start is held high.
  - A fresh interval needs start to go low, then high again.
- done is 0 in every cycle except the expiry cycle.
- Reset mid-RUN aborts immediately: timing falls asynchronously and no done pulse is produced.
- remain_sec never wraps below 0.
- The prescaler counter width is ceil(log2(CLK_FREQ_HZ)).

Test Plan (bench overrides CLK_FREQ_HZ=10, TIME_S=3; 10 ns clk):
1. Reset:
   - Hold reset=0 for 5 cycles with start=1 → timing=0, done=0, remain_sec=0 throughout.
   - Release reset with start=0 → all outputs stay 0.
2. Basic run:
   - Raise start (keep it high) → timing=1 on the next edge, remain_sec=3.
   - remain_sec becomes 2, 1, 0 at 10-cycle intervals.
   - timing is high for exactly 30 cycles; done pulses once, in the cycle timing falls.
3. Held start:
   - After scenario 2, keep start=1 for 50 more cycles → timing stays 0 (HOLD).
   - Drop start for 1 cycle and raise it again → a new 30-cycle interval begins.
4. Start during RUN:
   - Toggle start repeatedly mid-interval → interval length stays 30 cycles; remain_sec is not reloaded.
5. Reset mid-run:
   - Assert reset at cycle 15 of RUN → timing drops without waiting for clk; done stays 0; remain_sec=0.
6. Single-cycle start pulse:
   - start=1 for one cycle only → full 30-cycle interval runs, then the FSM returns to IDLE via HOLD.
